// File: rtl/console_pkg.sv
// Shared definitions for the console writer: screen geometry, control codes,
// screen-controller print commands, FSM states and the ASCII-to-glyph map.
package console_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 60;

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_DEL = 8'h7F;

    localparam logic [1:0] PR_IDLE  = 2'b00;
    localparam logic [1:0] PR_ADDR  = 2'b01;
    localparam logic [1:0] PR_WRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_ADDR      = 3'd2,
        ST_WRITE     = 3'd3,
        ST_ADV       = 3'd4,
        ST_CLR_ADDR  = 3'd5,
        ST_CLR_WRITE = 3'd6
    } state_e;

    // Lowercase folds onto uppercase; anything without a glyph becomes blank.
    function automatic logic [5:0] ascii_to_glyph(input logic [7:0] b, input logic [5:0] blank);
        logic [7:0] d;
        if (b >= 8'h20 && b <= 8'h5F) begin
            d = b - 8'h20;
        end else if (b >= 8'h61 && b <= 8'h7A) begin
            d = b - 8'h40;
        end else begin
            d = {2'b00, blank};
        end
        return d[5:0];
    endfunction

    function automatic logic is_control(input logic [7:0] b);
        return (b < 8'h20) || (b == CC_DEL);
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derive from the count.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW + 1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/console_writer.sv
// Character-stream front end for the text screen controller: buffers bytes,
// tracks the cursor, decodes control codes and issues latch/write pulses.
module console_writer
    import console_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [5:0] BLANK      = 6'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    output logic [1:0]  print,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] char,
    output logic [6:0]  cur_x,
    output logic [5:0]  cur_y,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic [7:0]  fifo_data_s;
    logic [AW:0] fifo_count_s;
    logic [5:0]  adv_y_s;
    logic [1:0]  print_nxt_s;
    state_e      state_r;
    state_e      state_nxt_s;

    logic [7:0]  byte_r;
    logic [6:0]  cur_x_r;
    logic [5:0]  cur_y_r;
    logic [6:0]  x_r;
    logic [5:0]  y_r;
    logic [5:0]  char_r;
    logic [5:0]  clr_end_y_r;
    logic        is_bs_r;
    logic [1:0]  print_r;

    char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid && in_ready),
        .wr_data (in_char),
        .pop     (pop_s),
        .rd_data (fifo_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (fifo_count_s)
    );

    assign in_ready = !full_s;
    assign busy     = (fifo_count_s != '0) || (state_r != ST_IDLE);
    assign print    = print_r;
    assign x        = {25'd0, x_r};
    assign y        = {26'd0, y_r};
    assign char     = {26'd0, char_r};
    assign cur_x    = cur_x_r;
    assign cur_y    = cur_y_r;
    assign adv_y_s  = (cur_y_r == ROW_LAST) ? 6'd0 : cur_y_r + 6'd1;

    // Next-state decode and FIFO pop request.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (!is_control(byte_r)) begin
                    state_nxt_s = ST_ADDR;
                end else if (byte_r == CC_LF) begin
                    state_nxt_s = ST_ADV;
                end else if (byte_r == CC_BS) begin
                    state_nxt_s = (cur_x_r == 7'd0 && cur_y_r == 6'd0) ? ST_IDLE : ST_ADDR;
                end else if (byte_r == CC_FF) begin
                    state_nxt_s = ST_CLR_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR:     state_nxt_s = ST_WRITE;
            ST_WRITE: begin
                if (!is_bs_r && cur_x_r == COL_LAST) begin
                    state_nxt_s = ST_ADV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADV:      state_nxt_s = ST_CLR_ADDR;
            ST_CLR_ADDR: state_nxt_s = ST_CLR_WRITE;
            ST_CLR_WRITE: begin
                if (x_r == COL_LAST && y_r == clr_end_y_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLR_ADDR;
                end
            end
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // The print command follows the state being entered so it is registered.
    always_comb begin
        case (state_nxt_s)
            ST_ADDR, ST_CLR_ADDR:   print_nxt_s = PR_ADDR;
            ST_WRITE, ST_CLR_WRITE: print_nxt_s = PR_WRITE;
            default:                print_nxt_s = PR_IDLE;
        endcase
    end

    // State, cursor and write-port registers; x/y double as the clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            byte_r      <= 8'd0;
            cur_x_r     <= 7'd0;
            cur_y_r     <= 6'd0;
            x_r         <= 7'd0;
            y_r         <= 6'd0;
            char_r      <= 6'd0;
            clr_end_y_r <= 6'd0;
            is_bs_r     <= 1'b0;
            print_r     <= PR_IDLE;
        end else begin
            state_r <= state_nxt_s;
            print_r <= print_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) byte_r <= fifo_data_s;
                end
                ST_DECODE: begin
                    if (!is_control(byte_r)) begin
                        x_r     <= cur_x_r;
                        y_r     <= cur_y_r;
                        char_r  <= ascii_to_glyph(byte_r, BLANK);
                        is_bs_r <= 1'b0;
                    end else if (byte_r == CC_LF || byte_r == CC_CR) begin
                        cur_x_r <= 7'd0;
                    end else if (byte_r == CC_BS) begin
                        if (cur_x_r != 7'd0) begin
                            cur_x_r <= cur_x_r - 7'd1;
                            x_r     <= cur_x_r - 7'd1;
                            y_r     <= cur_y_r;
                            char_r  <= BLANK;
                            is_bs_r <= 1'b1;
                        end else if (cur_y_r != 6'd0) begin
                            cur_x_r <= COL_LAST;
                            cur_y_r <= cur_y_r - 6'd1;
                            x_r     <= COL_LAST;
                            y_r     <= cur_y_r - 6'd1;
                            char_r  <= BLANK;
                            is_bs_r <= 1'b1;
                        end
                    end else if (byte_r == CC_FF) begin
                        cur_x_r     <= 7'd0;
                        cur_y_r     <= 6'd0;
                        x_r         <= 7'd0;
                        y_r         <= 6'd0;
                        char_r      <= BLANK;
                        clr_end_y_r <= ROW_LAST;
                    end
                end
                ST_WRITE: begin
                    if (!is_bs_r) begin
                        cur_x_r <= (cur_x_r == COL_LAST) ? 7'd0 : cur_x_r + 7'd1;
                    end
                end
                ST_ADV: begin
                    cur_y_r     <= adv_y_s;
                    x_r         <= 7'd0;
                    y_r         <= adv_y_s;
                    char_r      <= BLANK;
                    clr_end_y_r <= adv_y_s;
                end
                ST_CLR_WRITE: begin
                    if (x_r == COL_LAST) begin
                        if (y_r != clr_end_y_r) begin
                            x_r <= 7'd0;
                            y_r <= y_r + 6'd1;
                        end
                    end else begin
                        x_r <= x_r + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: a cursor-level model predicts every
// glyph write, and a monitor checks the DUT's write pulses against it.
module tb_console_writer;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
        logic [5:0] c;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'd0;
    logic [1:0]  print;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] char;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic        busy;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];
    int   mx = 0;
    int   my = 0;
    int   addr_cnt = 0;
    int   wr_cnt = 0;
    int   accepted = 0;
    int   first_block = -1;
    logic [31:0] lat_x = 32'd0;
    logic [31:0] lat_y = 32'd0;

    console_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .print    (print),
        .x        (x),
        .y        (y),
        .char     (char),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [5:0] glyph_ref(input int b);
        if (b >= 32 && b <= 95) return 6'(b - 32);
        if (b >= 97 && b <= 122) return 6'(b - 64);
        return 6'd0;
    endfunction

    function automatic void push_exp(input int cx, input int cy, input logic [5:0] c);
        wr_t w;
        w.x = 7'(cx);
        w.y = 6'(cy);
        w.c = c;
        exp_q.push_back(w);
    endfunction

    function automatic void new_line();
        my = (my + 1) % 60;
        for (int i = 0; i < 80; i++) push_exp(i, my, 6'd0);
    endfunction

    function automatic void model_byte(input int b);
        if (b >= 32 && b != 127) begin
            push_exp(mx, my, glyph_ref(b));
            mx = mx + 1;
            if (mx == 80) begin
                mx = 0;
                new_line();
            end
        end else if (b == 10) begin
            mx = 0;
            new_line();
        end else if (b == 13) begin
            mx = 0;
        end else if (b == 8) begin
            if (mx > 0) begin
                mx = mx - 1;
                push_exp(mx, my, 6'd0);
            end else if (my > 0) begin
                mx = 79;
                my = my - 1;
                push_exp(mx, my, 6'd0);
            end
        end else if (b == 12) begin
            mx = 0;
            my = 0;
            for (int r = 0; r < 60; r++)
                for (int c = 0; c < 80; c++) push_exp(c, r, 6'd0);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (print == 2'b01) begin
                lat_x = x;
                lat_y = y;
                addr_cnt++;
            end else if (print == 2'b10) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got x=%0d y=%0d char=%0d, none expected", x, y, char);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (x !== {25'd0, e.x} || y !== {26'd0, e.y} || char !== {26'd0, e.c} ||
                        lat_x !== x || lat_y !== y) begin
                        errors++;
                        $display("FAIL write got x=%0d y=%0d char=%0d latched=(%0d,%0d) expected x=%0d y=%0d char=%0d",
                                 x, y, char, lat_x, lat_y, e.x, e.y, e.c);
                    end
                end
            end else if (print != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL print_code got %b expected 00/01/10", print);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with in_valid still high.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_char  = b;
        if (!in_ready && first_block < 0) first_block = accepted;
        while (!in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 expected 1 byte=%0h", b);
        end else begin
            @(posedge clk);
            accepted++;
            model_byte(int'(b));
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        in_valid = 1'b0;
        while ((busy || exp_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got busy=%0d pending=%0d expected 0 0", name, busy, exp_q.size());
        end
        chk({name, "_cur_x"}, {25'd0, cur_x}, 32'(mx));
        chk({name, "_cur_y"}, {26'd0, cur_y}, 32'(my));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        mx = 0;
        my = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        do_reset();
        chk("rst_print", {30'd0, print}, 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_char", char, 32'd0);
        chk("rst_cur", {19'd0, cur_x, cur_y}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single 'A'
        send(8'h41);
        drain("char_A");
        chk("A_char_held", char, 32'h21);
        chk("A_cur_x", {25'd0, cur_x}, 32'd1);

        // 80 'Z' wrap into row 1 with row clear
        do_reset();
        for (int i = 0; i < 80; i++) send(8'h5A);
        drain("row_wrap");
        chk("wrap_cur", {19'd0, cur_x, cur_y}, {19'd0, 7'd0, 6'd1});

        // LF wrap from the last row
        do_reset();
        for (int i = 0; i < 59; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61);
        drain("to_last_row");
        chk("last_row_cur", {19'd0, cur_x, cur_y}, {19'd0, 7'd5, 6'd59});
        send(8'h0A);
        drain("lf_wrap");
        chk("lf_wrap_cur", {19'd0, cur_x, cur_y}, 32'd0);

        // backspace across a row boundary, then at origin
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h0A);
        send(8'h08);
        drain("bs_row");
        chk("bs_row_cur", {19'd0, cur_x, cur_y}, {19'd0, 7'd79, 6'd2});
        do_reset();
        base = addr_cnt + wr_cnt;
        send(8'h08);
        send(8'h0D);
        drain("bs_origin");
        repeat (4) @(negedge clk);
        chk("bs_origin_no_print", 32'(addr_cnt + wr_cnt - base), 32'd0);

        // form feed: full-screen clear
        send(8'h33);
        send(8'h0C);
        base = wr_cnt;
        drain("ff");
        chk("ff_writes", 32'(wr_cnt - base), 32'd4801);

        // back-pressure burst: FF keeps the FSM busy while 19 chars queue
        do_reset();
        accepted = 0;
        first_block = -1;
        send(8'h0C);
        for (int i = 0; i < 19; i++) send(8'(8'h41 + i));
        drain("burst");
        chk("burst_accept_before_full", 32'(first_block), 32'd17);
        chk("burst_accepted", 32'(accepted), 32'd20);

        // randomized traffic with occasional idle gaps
        for (int i = 0; i < 150; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            if (r == 8'h0C) r = 8'h7A;
            send(r);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
        end
        drain("random");

        // reset in the middle of a burst
        send(8'h0C);
        for (int i = 0; i < 10; i++) send(8'h42);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_print", {30'd0, print}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_cur", {19'd0, cur_x, cur_y}, 32'd0);
        exp_q.delete();
        mx = 0;
        my = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h43);
        drain("after_midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/console_writer.md
Name: console_writer

Overview:
- Character-stream front end for the VGA text screen controller.
- Accepts ASCII bytes from the CPU print path (syscall/MMIO store) through a small FIFO.
- Tracks an 80x60 text cursor, decodes control codes, and drives the screen controller's two-step write protocol. print=01 latches the grid address from x/y; the following print=10 writes char.
- Sits directly upstream of the screen controller, in the CPU clock domain.

Parameters:
- COLS, 80, text columns.
- ROWS, 60, text rows.
- FIFO_DEPTH, 16, input FIFO entries (power of two).
- BLANK, 6'd0, glyph code written for blank cells.

Ports:
- clk  in  1  CPU clock; same clock as the screen controller's write port.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte offered.
- in_ready  out  1  FIFO not full; transfer on in_valid&&in_ready.
- in_char  in  8  ASCII byte.
- print  out  2  00 idle, 01 latch address, 10 write glyph.
- x  out  32  column, zero-extended.
- y  out  32  row, zero-extended.
- char  out  32  glyph code in bits [5:0], upper bits 0.
- cur_x  out  7  current cursor column.
- cur_y  out  6  current cursor row.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - FIFO flushed; FSM to IDLE.
  - Outputs: print=00, x=y=char=0, cur_x=cur_y=0, busy=0, in_ready=1.
  - Reset mid-operation abandons any pending write or clear. A cell may be left with only print=01 issued; that is harmless.
- FIFO:
  - in_ready=!full, combinational from the occupancy count.
  - Simultaneous push and pop leave the count unchanged.
  - Pop only in IDLE when non-empty.
- Glyph map:
  - 0x20-0x5F -> byte-0x20.
  - 0x61-0x7A -> byte-0x40 (folded to uppercase).
  - Any other non-control byte -> BLANK.
- FSM states: IDLE, DECODE, ADDR, WRITE, ADV, CLR_ADDR, CLR_WRITE.
  - IDLE: if FIFO non-empty, pop into a byte register -> DECODE.
  - DECODE (printable): set x=cur_x, y=cur_y, char=glyph -> ADDR.
  - DECODE 0x0A (LF): cur_x=0 -> ADV.
  - DECODE 0x0D (CR): cur_x=0 -> IDLE.
  - DECODE 0x08 (BS):
    - cur_x>0: cur_x-1.
    - cur_x==0 and cur_y>0: cur_x=COLS-1, cur_y-1.
    - At (0,0): no-op -> IDLE.
    - Otherwise write BLANK at the new cursor via ADDR/WRITE; the cursor does not advance after that write.
  - DECODE 0x0C (FF): cur_x=cur_y=0; clear all COLS*ROWS cells -> CLR_ADDR.
  - DECODE, other control bytes below 0x20 and 0x7F: ignored -> IDLE.
  - ADDR: print=01 for one cycle -> WRITE.
  - WRITE: print=10 for one cycle with x, y, char held stable.
    - Printable: cur_x+1. If cur_x==COLS-1, cur_x=0 -> ADV; else -> IDLE.
    - BS: -> IDLE.
  - ADV: cur_y = (cur_y==ROWS-1) ? 0 : cur_y+1 (wrap, no scroll). Then clear destination row cur_y, columns 0..COLS-1 -> CLR_ADDR.
  - CLR_ADDR/CLR_WRITE: alternate print=01/10 with char=BLANK, stepping the clear counter.
    - Row clear: 2*COLS=160 cycles.
    - Full-screen clear: 2*COLS*ROWS=9600 cycles, row-major.
    - Then -> IDLE.
- print is 00 in every state other than ADDR, WRITE, CLR_ADDR, CLR_WRITE.
- x, y, char are registered and hold their last values when idle.
- Latency, idle block with empty FIFO, byte accepted at edge N:
  - pop at N+1, DECODE at N+2;
  - print=01 during cycle N+3, print=10 during N+4;
  - back to IDLE at N+5.
  - Sustained printable throughput: 1 char per 4 cycles.
- Inputs are never dropped: back-pressure goes through in_ready only.

Decomposition:
- Shared package `console_pkg`:
  - COLS and ROWS;
  - control-code constants CC_LF, CC_CR, CC_BS, CC_FF;
  - print-command encodings PR_IDLE=00, PR_ADDR=01, PR_WRITE=10;
  - FSM state enum;
  - ascii_to_glyph function.
- One sub-module: `char_fifo` (parameterised synchronous FIFO, async active-low reset, full/empty/count).

Test Plan:
- Reset, then push 'A' (0x41) -> print=01 with x=0,y=0, next cycle print=10 char=0x21; cur_x=1; busy falls one cycle later.
- Push 80 'Z' bytes from (0,0) -> last write at x=79,y=0; then 160 cycles of clear on row 1 (char=0); cursor ends at (0,1).
- Cursor at (5,59), push 0x0A -> cur_y wraps to 0, row 0 cleared (x=0..79,y=0), cursor (0,0).
- Push 0x08 at (0,3) -> blank written at (79,2), cursor (79,2). Push 0x08 at (0,0) -> no print activity.
- Push 0x0C -> exactly 4800 print=10 pulses with char=0, covering (0,0) through (79,59); cursor (0,0).
- Push 20 bytes back-to-back with in_valid held high -> in_ready drops after 16 are buffered; all 20 are written in order, none lost. Assert rst_n low mid-burst -> print=00 immediately, busy=0, FIFO empty.
